// File: rtl/led_indicator_pkg.sv
// ---------------------------------------------------------------------------
// led_indicator_pkg
//
// Shared types and constants for the LED indicator controller:
//   - led_mode_e   : per-channel mode codes (codes 5..7 are not members and
//                    decode as OFF)
//   - MODE_W       : width of one channel's mode field
//   - breath_dir_e : direction of the breathing triangle
//   - cnt_width()  : counter width for a counter that counts 0..terminal-1
//
// Optional feature macro used by this slice: LED_BREATH_EN
// ---------------------------------------------------------------------------
package led_indicator_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 3'd0,
        MODE_SOLID  = 3'd1,
        MODE_BLINK  = 3'd2,
        MODE_BREATH = 3'd3,
        MODE_AUTO   = 3'd4
    } led_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } breath_dir_e;

    // Width of a counter whose terminal value is 'terminal'; never below 1 bit
    // so degenerate configurations still produce a legal vector.
    function automatic int cnt_width(input int terminal);
        return (terminal <= 1) ? 1 : $clog2(terminal);
    endfunction

endpackage : led_indicator_pkg

// File: rtl/led_breath_gen.sv
// ---------------------------------------------------------------------------
// led_breath_gen
//
// Shared breathing generator: a free-running PWM counter, a step prescaler
// counting PWM periods, and an UP/DOWN direction FSM that walks the duty
// cycle 0..PWM_MAX..0 as a triangle. The duty register only changes on the
// last cycle of a PWM period, so a new duty always starts with a fresh period.
//
// Instantiated by led_indicator only when LED_BREATH_EN is defined.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   sync_i   in   restart pulse: clears counters and duty, FSM back to UP
//   pwm_out  out  PWM level for the current duty (combinational from regs)
// ---------------------------------------------------------------------------
module led_breath_gen
    import led_indicator_pkg::*;
#(
    parameter int PWM_BITS     = 3,
    parameter int STEP_PERIODS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    output logic pwm_out
);

    localparam int PWM_MAX = (1 << PWM_BITS) - 1;
    localparam int PWM_CW  = cnt_width(PWM_MAX);
    localparam int STEP_CW = cnt_width(STEP_PERIODS);

    logic [PWM_CW-1:0]   pwm_cnt_q,  pwm_cnt_d;
    logic [STEP_CW-1:0]  step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] duty_q,     duty_d;
    breath_dir_e         dir_q,      dir_d;

    logic pwm_wrap;
    logic step_evt;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path through the block leaves it unassigned and no latch appears.
    always_comb begin
        pwm_wrap   = (pwm_cnt_q == PWM_CW'(PWM_MAX - 1));
        step_evt   = pwm_wrap && (step_cnt_q == STEP_CW'(STEP_PERIODS - 1));

        pwm_cnt_d  = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
        step_cnt_d = step_cnt_q;
        duty_d     = duty_q;
        dir_d      = dir_q;

        if (step_evt) begin
            step_cnt_d = '0;
        end else if (pwm_wrap) begin
            step_cnt_d = step_cnt_q + 1'b1;
        end

        // At either end of the triangle the turning step holds the duty, so
        // both extremes are shown for two consecutive steps.
        if (step_evt) begin
            case (dir_q)
                DIR_UP: begin
                    if (duty_q != '1) duty_d = duty_q + 1'b1;
                    else              dir_d  = DIR_DOWN;
                end
                DIR_DOWN: begin
                    if (duty_q != '0) duty_d = duty_q - 1'b1;
                    else              dir_d  = DIR_UP;
                end
                default: dir_d = DIR_UP;
            endcase
        end

        // Restart wins over any wrap or step landing on the same cycle.
        if (sync_i) begin
            pwm_cnt_d  = '0;
            step_cnt_d = '0;
            duty_d     = '0;
            dir_d      = DIR_UP;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            duty_q     <= '0;
            dir_q      <= DIR_UP;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
        end
    end

    // pwm_cnt never reaches PWM_MAX, so duty PWM_MAX is lit for the whole
    // period and duty 0 never lights.
    assign pwm_out = (pwm_cnt_q < duty_q);

endmodule : led_breath_gen

// File: rtl/led_indicator.sv
// ---------------------------------------------------------------------------
// led_indicator
//
// Multi-channel LED indicator controller. All channels share one blink
// timebase and (optionally) one breathing generator so patterns stay in phase
// across the panel. Each channel picks OFF / SOLID / BLINK / BREATH / AUTO;
// AUTO derives the pattern from fan enable, charger and battery level. The
// LED outputs are registered: an input change shows one clock later.
//
// Optional feature macro: LED_BREATH_EN
//   defined   : led_breath_gen is built and drives BREATH patterns.
//   undefined : no breath generator; BREATH and AUTO-while-charging show
//               SOLID, and sync only restarts the blink timebase.
//
// Ports:
//   clk       in   system clock (100 Hz)
//   rst_n     in   asynchronous active-low reset
//   fan_en    in   fan not in neutral; AUTO channels dark when 0
//   battery   in   battery level 0..255
//   charging  in   charger active
//   sync      in   single-cycle pulse restarting both timebases
//   mode      in   per-channel mode, channel i at [3i+2:3i]
//   led       out  LED drive per channel, 1 = lit
// ---------------------------------------------------------------------------
module led_indicator
    import led_indicator_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int PWM_BITS     = 3,
    parameter int STEP_PERIODS = 1,
    parameter int BLINK_HALF   = 25,
    parameter int LOW_THR      = 25,
    parameter int FULL_LVL     = 99
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fan_en,
    input  logic [7:0]               battery,
    input  logic                     charging,
    input  logic                     sync,
    input  logic [MODE_W*NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0]        led
);

    localparam int         BLINK_CW = cnt_width(BLINK_HALF);
    localparam logic [7:0] LOW_LVL  = 8'(LOW_THR);
    localparam logic [7:0] FULL_BAT = 8'(FULL_LVL);

    // Reject parameter sets the pattern logic cannot represent.
    if (BLINK_HALF < 1 || STEP_PERIODS < 1 || PWM_BITS < 1 ||
        FULL_LVL <= LOW_THR || FULL_LVL > 255 || LOW_THR < 0) begin : g_bad_cfg
        $error("led_indicator: illegal parameter combination");
    end

    // -----------------------------------------------------------------------
    // Blink timebase
    // -----------------------------------------------------------------------
    logic [BLINK_CW-1:0] blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic                blink_wrap;

    always_comb begin
        blink_wrap    = (blink_cnt_q == BLINK_CW'(BLINK_HALF - 1));
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;

        if (sync) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // -----------------------------------------------------------------------
    // Breathing level
    // -----------------------------------------------------------------------
    logic breath_lvl;

`ifdef LED_BREATH_EN
    led_breath_gen #(
        .PWM_BITS     (PWM_BITS),
        .STEP_PERIODS (STEP_PERIODS)
    ) u_breath_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_i  (sync),
        .pwm_out (breath_lvl)
    );
`else
    // With no generator, anything that would breathe is simply lit.
    assign breath_lvl = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // AUTO pattern: shared by every AUTO channel, first match wins
    // -----------------------------------------------------------------------
    logic auto_lvl;

    always_comb begin
        auto_lvl = 1'b0;
        if (!fan_en) begin
            auto_lvl = 1'b0;
        end else if (charging && (battery < FULL_BAT)) begin
            auto_lvl = breath_lvl;
        end else if (battery >= FULL_BAT) begin
            auto_lvl = 1'b1;
        end else if (battery <= LOW_LVL) begin
            auto_lvl = blink_phase_q;
        end else begin
            auto_lvl = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel decode and output register
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] led_d, led_q;

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode[i*MODE_W +: MODE_W])
                MODE_SOLID:  led_d[i] = 1'b1;
                MODE_BLINK:  led_d[i] = blink_phase_q;
                MODE_BREATH: led_d[i] = breath_lvl;
                MODE_AUTO:   led_d[i] = auto_lvl;
                default:     led_d[i] = 1'b0;   // OFF and unused codes 5..7
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule : led_indicator

// File: tb/tb_led_indicator.sv
// ---------------------------------------------------------------------------
// tb_led_indicator
//
// Directed self-checking bench for led_indicator with default parameters
// (3 channels, PWM_BITS=3, STEP_PERIODS=1, BLINK_HALF=25, LOW_THR=25,
// FULL_LVL=99). Breath-specific expectations follow LED_BREATH_EN.
// Cycle n means "after the n-th rising edge following reset release or a
// sync edge"; outputs are sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_led_indicator;

    localparam int HALF = 25;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       fan_en   = 1'b0;
    logic [7:0] battery  = 8'd0;
    logic       charging = 1'b0;
    logic       sync     = 1'b0;
    logic [8:0] mode     = 9'd0;
    logic [2:0] led;

    int errors = 0;
    int checks = 0;

    // Hand-derived high counts per 7-cycle PWM period over one breath cycle.
    int breath_tbl [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0};

    led_indicator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fan_en   (fan_en),
        .battery  (battery),
        .charging (charging),
        .sync     (sync),
        .mode     (mode),
        .led      (led)
    );

    always #5 clk = ~clk;

    // Blink level expected at cycle m after a timebase restart.
    function automatic logic blink_ref(input int m);
        return (((m - 1) / HALF) % 2) == 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sync  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic sync_pulse();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    task automatic test_reset();
        mode   = 9'b001_001_001;
        fan_en = 1'b1;
        rst_n  = 1'b0;
        #1;
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL reset_value: led=%b expected 000", led);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (led !== 3'b111) begin
            errors++;
            $display("FAIL solid_after_reset: led=%b expected 111", led);
        end
        // Asynchronous clear well away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: led=%b expected 000", led);
        end
        do_reset();
    endtask

    task automatic test_blink_from_reset();
        logic [2:0] expv;
        mode = 9'b010_010_010;
        do_reset();
        for (int n = 1; n <= 4 * HALF; n++) begin
            tick();
            expv = blink_ref(n) ? 3'b111 : 3'b000;
            checks++;
            if (led !== expv) begin
                errors++;
                $display("FAIL blink_reset cycle %0d: led=%b expected %b", n, led, expv);
            end
        end
    endtask

    task automatic test_auto();
        logic [2:0] expv;
        mode     = 9'b000_000_100;
        fan_en   = 1'b1;
        charging = 1'b0;
        battery  = 8'd26;
        tick();
        for (int n = 0; n < 30; n++) begin
            tick();
            checks++;
            if (led !== 3'b001) begin
                errors++;
                $display("FAIL auto_bat26 cycle %0d: led=%b expected 001", n, led);
            end
        end
        // At the low threshold AUTO blinks in the shared phase.
        battery = 8'd25;
        sync_pulse();
        for (int m = 1; m <= 60; m++) begin
            tick();
            expv = {2'b00, blink_ref(m)};
            checks++;
            if (led !== expv) begin
                errors++;
                $display("FAIL auto_bat25 cycle %0d: led=%b expected %b", m, led, expv);
            end
        end
        // led is 0 at cycle 60; full battery must show exactly one clock later.
        battery = 8'd99;
        #1;
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL auto_latency_pre: led=%b expected 000", led);
        end
        tick();
        checks++;
        if (led !== 3'b001) begin
            errors++;
            $display("FAIL auto_bat99: led=%b expected 001", led);
        end
        // Full and charging: steady in both builds.
        charging = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (led !== 3'b001) begin
                errors++;
                $display("FAIL auto_full_charging cycle %0d: led=%b expected 001", n, led);
            end
        end
        charging = 1'b0;
        fan_en   = 1'b0;
        #1;
        checks++;
        if (led !== 3'b001) begin
            errors++;
            $display("FAIL fan_off_pre: led=%b expected 001", led);
        end
        tick();
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL fan_off: led=%b expected 000", led);
        end
        // Empty battery with the fan back on blinks again.
        fan_en  = 1'b1;
        battery = 8'd0;
        sync_pulse();
        for (int m = 1; m <= 30; m++) begin
            tick();
            expv = {2'b00, blink_ref(m)};
            checks++;
            if (led !== expv) begin
                errors++;
                $display("FAIL auto_bat0 cycle %0d: led=%b expected %b", m, led, expv);
            end
        end
    endtask

    task automatic test_sync();
        logic [2:0] expv;
        mode = 9'b010_010_010;
        do_reset();
        for (int n = 1; n <= HALF - 1; n++) begin
            tick();
            checks++;
            if (led !== 3'b000) begin
                errors++;
                $display("FAIL sync_pre cycle %0d: led=%b expected 000", n, led);
            end
        end
        // blink_cnt is now 24: this edge would wrap, but sync must win.
        sync = 1'b1;
        tick();
        sync = 1'b0;
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL sync_edge: led=%b expected 000", led);
        end
        for (int m = 1; m <= 2 * HALF; m++) begin
            tick();
            expv = blink_ref(m) ? 3'b111 : 3'b000;
            checks++;
            if (led !== expv) begin
                errors++;
                $display("FAIL sync_post cycle %0d: led=%b expected %b", m, led, expv);
            end
        end
    endtask

`ifdef LED_BREATH_EN
    task automatic test_breath();
        int hi [3];
        int expv;
        // ch2 SOLID, ch1 BREATH, ch0 AUTO while charging.
        mode     = 9'b001_011_100;
        fan_en   = 1'b1;
        charging = 1'b1;
        battery  = 8'd50;
        sync_pulse();
        for (int p = 0; p < 26; p++) begin
            hi = '{0, 0, 0};
            for (int c = 0; c < 7; c++) begin
                tick();
                for (int k = 0; k < 3; k++) hi[k] += int'(led[k]);
            end
            expv = breath_tbl[p % 16];
            checks++;
            if (hi[0] !== expv || hi[1] !== expv || hi[2] !== 7) begin
                errors++;
                $display("FAIL breath period %0d: highs ch0=%0d ch1=%0d ch2=%0d expected %0d %0d 7",
                         p, hi[0], hi[1], hi[2], expv, expv);
            end
        end
        // Now mid-descent: sync must restart at duty 0 heading up.
        sync_pulse();
        for (int p = 0; p < 16; p++) begin
            hi = '{0, 0, 0};
            for (int c = 0; c < 7; c++) begin
                tick();
                for (int k = 0; k < 3; k++) hi[k] += int'(led[k]);
            end
            expv = breath_tbl[p];
            checks++;
            if (hi[0] !== expv || hi[1] !== expv) begin
                errors++;
                $display("FAIL breath_sync period %0d: highs ch0=%0d ch1=%0d expected %0d",
                         p, hi[0], hi[1], expv);
            end
        end
        charging = 1'b0;
    endtask
`else
    task automatic test_breath();
        mode     = 9'b011_011_100;
        fan_en   = 1'b1;
        charging = 1'b1;
        battery  = 8'd50;
        for (int n = 0; n < 40; n++) begin
            sync = (n == 20);
            tick();
            checks++;
            if (led !== 3'b111) begin
                errors++;
                $display("FAIL breath_as_solid cycle %0d: led=%b expected 111", n, led);
            end
        end
        sync     = 1'b0;
        charging = 1'b0;
    endtask
`endif

    task automatic test_invalid_modes();
        logic [8:0] bad [3];
        bad    = '{9'b111_110_101, 9'b101_111_110, 9'b110_101_111};
        fan_en = 1'b1;
        for (int v = 0; v < 3; v++) begin
            mode = bad[v];
            for (int n = 0; n < 3; n++) begin
                tick();
                checks++;
                if (led !== 3'b000) begin
                    errors++;
                    $display("FAIL invalid_mode %b cycle %0d: led=%b expected 000", bad[v], n, led);
                end
            end
        end
        mode = 9'b001_001_001;
        #1;
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL to_solid_pre: led=%b expected 000", led);
        end
        tick();
        checks++;
        if (led !== 3'b111) begin
            errors++;
            $display("FAIL to_solid: led=%b expected 111", led);
        end
    endtask

    task automatic test_join_phase();
        logic [2:0] expv;
        logic       b;
        mode = 9'b000_000_010;
        sync_pulse();
        for (int m = 1; m <= 60; m++) begin
            // ch1 switches to BLINK partway and must join the running phase.
            if (m == 31) mode = 9'b000_010_010;
            tick();
            b    = blink_ref(m);
            expv = (m >= 31) ? {1'b0, b, b} : {2'b00, b};
            checks++;
            if (led !== expv) begin
                errors++;
                $display("FAIL join_phase cycle %0d: led=%b expected %b", m, led, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink_from_reset();
        test_auto();
        test_sync();
        test_breath();
        test_invalid_modes();
        test_join_phase();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_led_indicator

// File: doc/led_indicator.md
# led_indicator

Multi-channel LED indicator controller for the fan controller's status panel, running entirely on the 100 Hz system clock with no derived clocks. Each channel independently shows OFF, SOLID, BLINK, BREATH, or AUTO. AUTO derives the pattern from battery level, charging state and fan enable. All channels share one blink timebase and one breathing (triangle-PWM) generator, so patterns stay phase-aligned across the panel.

## Interface
Parameters:
- NUM_CH, 3: number of LED channels.
- PWM_BITS, 3: PWM resolution; PWM_MAX = 2^PWM_BITS − 1, and duty ranges 0..PWM_MAX.
- STEP_PERIODS, 1: PWM periods per breathing duty step (≥1).
- BLINK_HALF, 25: clk cycles per blink half-period; 25 gives 2 Hz at 100 Hz.
- LOW_THR, 25: battery level at or below which AUTO blinks.
- FULL_LVL, 99: battery level at or above which the battery counts as full. Must be > LOW_THR.

Ports:
- clk  in  1  system clock (100 Hz).
- rst_n  in  1  asynchronous, active-low reset.
- fan_en  in  1  fan not in neutral; AUTO channels are off when 0.
- battery  in  8  battery level 0–255.
- charging  in  1  charger active.
- sync  in  1  single-cycle pulse that restarts both timebases.
- mode  in  3·NUM_CH  per-channel mode; channel i uses bits [3i+2:3i].
- led  out  NUM_CH  LED drive; 1 = lit.

## Operation
- Mode codes:
  - 0 OFF → 0.
  - 1 SOLID → 1.
  - 2 BLINK → blink_phase.
  - 3 BREATH → pwm_out.
  - 4 AUTO → battery-derived pattern.
  - 5–7 → treated as OFF.
- AUTO priority, first match wins:
  1. fan_en=0 → OFF.
  2. charging=1 and battery<FULL_LVL → BREATH.
  3. battery≥FULL_LVL → SOLID.
  4. battery≤LOW_THR → BLINK.
  5. otherwise → SOLID.
- Blink timebase: blink_cnt counts 0..BLINK_HALF−1. At terminal count it wraps to 0 and blink_phase toggles.
- Breath generator, PWM part:
  - pwm_cnt counts 0..PWM_MAX−1 and wraps.
  - pwm_out = (pwm_cnt < duty), so duty 0 is dark and duty PWM_MAX is fully lit.
- Breath generator, step control:
  - At each pwm_cnt wrap, step_cnt increments.
  - At step_cnt = STEP_PERIODS−1, step_cnt clears and a step event fires.
- Direction FSM, states UP and DOWN, evaluated on each step event:
  - UP: if duty<PWM_MAX, duty+1; else go to DOWN with duty held.
  - DOWN: if duty>0, duty−1; else go to UP with duty held.
  - Full breath cycle = 2·(PWM_MAX+1) step events.
- sync=1 forces blink_cnt, blink_phase, pwm_cnt, step_cnt and duty to 0 and the FSM to UP. sync takes priority over any simultaneous wrap or step event.
- All arithmetic is unsigned.
  - Battery comparisons are 8-bit.
  - Counter widths are $clog2 of their terminal value; minimum 1 bit.

## Timing
- Reset values:
  - led = 0.
  - blink_cnt = 0, blink_phase = 0.
  - pwm_cnt = 0, step_cnt = 0, duty = 0, FSM = UP.
- led is registered. A change on mode, battery, charging or fan_en is visible on led exactly 1 clk later.
- Blink timing:
  - First blink_phase rise occurs BLINK_HALF cycles after reset release.
  - A BLINK channel's led rises at cycle BLINK_HALF+1.
  - Period = 2·BLINK_HALF.
- Breath timing:
  - One PWM period = PWM_MAX cycles.
  - A duty change takes effect at the start of the next PWM period, never mid-period.
- Timebases run freely regardless of mode. A channel switching to BLINK or BREATH joins the current shared phase; it does not restart it.
- Reset asserted mid-pattern clears led within the same cycle (asynchronous). Patterns restart from their reset values on release.

## Configuration
- LED_BREATH_EN:
  - Defined: the breath generator is built and the behaviour is as above.
  - Undefined: the breath generator is omitted. Mode 3 and AUTO-while-charging both map to SOLID, and sync affects only the blink timebase.

## Structure
- Package led_indicator_pkg holds:
  - the mode enum typedef (OFF, SOLID, BLINK, BREATH, AUTO);
  - the MODE_W=3 constant;
  - the breath direction enum (UP, DOWN).
- Sub-module led_breath_gen contains pwm_cnt, step_cnt, duty and the direction FSM, with output pwm_out. It is instantiated once, only under LED_BREATH_EN.
- The top level contains the blink timebase, per-channel mode decode and the output registers.

## Test plan
- Reset release, all channels BLINK (mode=3'd2 each) → led=3'b000 for cycles 1–25, 3'b111 for cycles 26–50, then toggles every 25 cycles.
- Channel 0 AUTO with fan_en=1, charging=0 → battery=26 gives led[0]=1 steady; battery=25 gives a 2 Hz blink; battery=99 gives steady 1; fan_en=0 forces 0 one cycle later.
- Channel 0 AUTO with charging=1, battery=50 (LED_BREATH_EN defined) → high count per 7-cycle PWM period follows 0,1,…,7,7,6,…,0,0. The pattern repeats every 112 cycles. With battery=99 and charging=1 the output is steady 1.
- sync pulse at blink_cnt=24, coinciding with a wrap → blink_phase stays 0 and the next rise is 25 cycles after sync; duty returns to 0 with FSM in UP.
- Modes 5, 6 and 7 on every channel → led=0. Switching to mode 1 gives led=1 on the next cycle.
- Build without LED_BREATH_EN, mode=3 → led steady 1. AUTO with charging=1 and battery=50 → steady 1.
